vx_csr_access: RTL and testbench

- Two-stage CSR execute pipeline that sits directly upstream of the per-core CSR data store.
- Accepts CSRRW/CSRRS/CSRRC requests from the issue stage and reads the addressed CSR through the data store's read port.
- Computes the read-modify-write value, drives the data store's write port, and returns the old CSR value to writeback, broadcast to all threads.
- Stalls accesses to floating-point CSRs while FPU ops of the same warp are in flight.

---
 rtl/vx_csr_access_if.sv | 69 ++++++
 rtl/vx_csr_access.sv | 130 +++++++++++++
 tb/tb_vx_csr_access.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_csr_access_if.sv
`default_nettype none
// ============================================================================
// Module      : vx_csr_access_if
// Description : Issue, CSR store read/write, writeback and status signals of
//               the CSR execute pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface vx_csr_access_if #(
    parameter int NUM_WARPS     = 4,
    parameter int NUM_THREADS   = 4,
    parameter int UUID_BITS     = 44,
    parameter int CSR_ADDR_BITS = 12
);
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                         req_valid;
    logic                         req_ready;
    logic [UUID_BITS-1:0]         req_uuid;
    logic [NW_BITS-1:0]           req_wid;
    logic [1:0]                   req_op;
    logic [CSR_ADDR_BITS-1:0]     req_addr;
    logic                         req_use_imm;
    logic [4:0]                   req_imm;
    logic [31:0]                  req_rs1_data;
    logic [4:0]                   req_rd;
    logic                         req_wb;
    logic [NUM_WARPS-1:0]         fpu_pending;

    logic                         read_enable;
    logic [UUID_BITS-1:0]         read_uuid;
    logic [NW_BITS-1:0]           read_wid;
    logic [CSR_ADDR_BITS-1:0]     read_addr;
    logic [31:0]                  read_data;

    logic                         write_enable;
    logic [UUID_BITS-1:0]         write_uuid;
    logic [NW_BITS-1:0]           write_wid;
    logic [CSR_ADDR_BITS-1:0]     write_addr;
    logic [31:0]                  write_data;

    logic                         busy;

    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [UUID_BITS-1:0]         rsp_uuid;
    logic [NW_BITS-1:0]           rsp_wid;
    logic [4:0]                   rsp_rd;
    logic                         rsp_wb;
    logic [NUM_THREADS*32-1:0]    rsp_data;

    modport master (
        output req_valid, req_uuid, req_wid, req_op, req_addr, req_use_imm,
               req_imm, req_rs1_data, req_rd, req_wb, fpu_pending,
               read_data, rsp_ready,
        input  req_ready, read_enable, read_uuid, read_wid, read_addr,
               write_enable, write_uuid, write_wid, write_addr, write_data,
               busy, rsp_valid, rsp_uuid, rsp_wid, rsp_rd, rsp_wb, rsp_data
    );

    modport slave (
        input  req_valid, req_uuid, req_wid, req_op, req_addr, req_use_imm,
               req_imm, req_rs1_data, req_rd, req_wb, fpu_pending,
               read_data, rsp_ready,
        output req_ready, read_enable, read_uuid, read_wid, read_addr,
               write_enable, write_uuid, write_wid, write_addr, write_data,
               busy, rsp_valid, rsp_uuid, rsp_wid, rsp_rd, rsp_wb, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/vx_csr_access.sv
`default_nettype none
// ============================================================================
// Module      : vx_csr_access
// Description : Two-stage CSRRW/RS/RC execute pipeline in front of the CSR
//               data store, with FP-CSR stall while FPU ops are in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_csr_access #(
    parameter int NUM_WARPS     = 4,
    parameter int NUM_THREADS   = 4,
    parameter int UUID_BITS     = 44,
    parameter int CSR_ADDR_BITS = 12
) (
    input  wire logic      clk,
    input  wire logic      reset,
    vx_csr_access_if.slave bus
);
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    localparam logic [1:0] c_op_rw = 2'd0;
    localparam logic [1:0] c_op_rs = 2'd1;
    localparam logic [1:0] c_op_rc = 2'd2;
    localparam logic [CSR_ADDR_BITS-1:0] c_csr_fflags = CSR_ADDR_BITS'(1);
    localparam logic [CSR_ADDR_BITS-1:0] c_csr_fcsr   = CSR_ADDR_BITS'(3);

    logic                       r_a_valid;
    logic [UUID_BITS-1:0]       r_a_uuid;
    logic [NW_BITS-1:0]         r_a_wid;
    logic [1:0]                 r_a_op;
    logic [CSR_ADDR_BITS-1:0]   r_a_addr;
    logic [4:0]                 r_a_rd;
    logic                       r_a_wb;
    logic [31:0]                r_a_operand;

    logic                       r_b_valid;
    logic [UUID_BITS-1:0]       r_b_uuid;
    logic [NW_BITS-1:0]         r_b_wid;
    logic [4:0]                 r_b_rd;
    logic                       r_b_wb;
    logic [NUM_THREADS*32-1:0]  r_b_data;

    logic                       w_b_free;
    logic [NUM_WARPS-1:0]       w_pend_shift;
    logic                       w_hazard;
    logic                       w_a_adv;
    logic                       w_req_fire;
    logic                       w_set_clr_zero;
    logic [31:0]                w_new_value;

    assign w_b_free     = !r_b_valid || bus.rsp_ready;
    assign w_pend_shift = bus.fpu_pending >> r_a_wid;
    assign w_hazard     = (r_a_addr >= c_csr_fflags) && (r_a_addr <= c_csr_fcsr)
                          && w_pend_shift[0];
    // Gating with reset keeps a discarded in-flight request from touching the store.
    assign w_a_adv      = reset && r_a_valid && w_b_free && !w_hazard;
    assign w_req_fire   = bus.req_valid && bus.req_ready;

    assign w_set_clr_zero = ((r_a_op == c_op_rs) || (r_a_op == c_op_rc))
                            && (r_a_operand == 32'd0);

    always_comb begin
        w_new_value = bus.read_data;
        case (r_a_op)
            c_op_rw: w_new_value = r_a_operand;
            c_op_rs: w_new_value = bus.read_data | r_a_operand;
            c_op_rc: w_new_value = bus.read_data & ~r_a_operand;
            default: w_new_value = bus.read_data;
        endcase
    end

    assign bus.req_ready    = reset && (!r_a_valid || w_a_adv);

    assign bus.read_enable  = w_a_adv;
    assign bus.read_uuid    = r_a_uuid;
    assign bus.read_wid     = r_a_wid;
    assign bus.read_addr    = r_a_addr;

    assign bus.write_enable = w_a_adv && !w_set_clr_zero && (r_a_op != 2'd3);
    assign bus.write_uuid   = r_a_uuid;
    assign bus.write_wid    = r_a_wid;
    assign bus.write_addr   = r_a_addr;
    assign bus.write_data   = w_new_value;

    assign bus.busy         = r_a_valid || r_b_valid;

    assign bus.rsp_valid    = r_b_valid;
    assign bus.rsp_uuid     = r_b_uuid;
    assign bus.rsp_wid      = r_b_wid;
    assign bus.rsp_rd       = r_b_rd;
    assign bus.rsp_wb       = r_b_wb;
    assign bus.rsp_data     = r_b_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a_valid <= 1'b0;
        end else if (w_req_fire) begin
            r_a_valid   <= 1'b1;
            r_a_uuid    <= bus.req_uuid;
            r_a_wid     <= bus.req_wid;
            r_a_op      <= bus.req_op;
            r_a_addr    <= bus.req_addr;
            r_a_rd      <= bus.req_rd;
            r_a_wb      <= bus.req_wb;
            r_a_operand <= bus.req_use_imm ? {27'd0, bus.req_imm} : bus.req_rs1_data;
        end else if (w_a_adv) begin
            r_a_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_b_valid <= 1'b0;
            r_b_uuid  <= '0;
            r_b_wid   <= '0;
            r_b_rd    <= '0;
            r_b_wb    <= 1'b0;
            r_b_data  <= '0;
        end else if (w_a_adv) begin
            r_b_valid <= 1'b1;
            r_b_uuid  <= r_a_uuid;
            r_b_wid   <= r_a_wid;
            r_b_rd    <= r_a_rd;
            r_b_wb    <= r_a_wb;
            r_b_data  <= {NUM_THREADS{bus.read_data}};
        end else if (bus.rsp_ready) begin
            r_b_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vx_csr_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_csr_access
// Description : Directed, table-driven bench for vx_csr_access with a simple
//               CSR data store attached to the read/write ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_csr_access;
    logic clk;
    logic reset;

    vx_csr_access_if #(.NUM_WARPS(4), .NUM_THREADS(4), .UUID_BITS(44), .CSR_ADDR_BITS(12)) bus ();

    vx_csr_access #(.NUM_WARPS(4), .NUM_THREADS(4), .UUID_BITS(44), .CSR_ADDR_BITS(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] store [4][4096];
    logic        pre_en;
    logic [1:0]  pre_wid;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    always_comb bus.read_data = store[bus.read_wid][bus.read_addr];

    always @(posedge clk) begin
        if (pre_en)
            store[pre_wid][pre_addr] <= pre_data;
        else if (bus.write_enable)
            store[bus.write_wid][bus.write_addr] <= bus.write_data;
    end

    typedef struct packed {
        logic [1:0]  wid;
        logic [1:0]  op;
        logic [11:0] addr;
        logic        use_imm;
        logic [4:0]  imm;
        logic [31:0] rs1;
        logic        wb;
        logic [31:0] pre;
        logic        exp_we;
        logic [31:0] exp_wd;
        logic [31:0] exp_rsp;
        logic [31:0] exp_fin;
    } vec_t;

    vec_t vecs [10];
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic preload(input logic [1:0] wid, input logic [11:0] addr, input logic [31:0] data);
        pre_en = 1'b1; pre_wid = wid; pre_addr = addr; pre_data = data;
        step;
        pre_en = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] wid, input logic [1:0] op, input logic [11:0] addr,
                             input logic use_imm, input logic [4:0] imm, input logic [31:0] rs1,
                             input logic [4:0] rd, input logic wb, input logic [43:0] uuid);
        bus.req_valid    = 1'b1;
        bus.req_wid      = wid;
        bus.req_op       = op;
        bus.req_addr     = addr;
        bus.req_use_imm  = use_imm;
        bus.req_imm      = imm;
        bus.req_rs1_data = rs1;
        bus.req_rd       = rd;
        bus.req_wb       = wb;
        bus.req_uuid     = uuid;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        preload(v.wid, v.addr, v.pre);
        drive_req(v.wid, v.op, v.addr, v.use_imm, v.imm, v.rs1, 5'(i + 1), v.wb, 44'(i + 100));
        settle;
        chk($sformatf("vec%0d_req_ready", i), 128'(bus.req_ready), 128'(1));
        step;
        bus.req_valid = 1'b0;
        settle;
        chk($sformatf("vec%0d_read_en", i), 128'(bus.read_enable), 128'(1));
        chk($sformatf("vec%0d_read_addr", i), 128'(bus.read_addr), 128'(v.addr));
        chk($sformatf("vec%0d_write_en", i), 128'(bus.write_enable), 128'(v.exp_we));
        if (v.exp_we)
            chk($sformatf("vec%0d_write_data", i), 128'(bus.write_data), 128'(v.exp_wd));
        step;
        settle;
        chk($sformatf("vec%0d_rsp_valid", i), 128'(bus.rsp_valid), 128'(1));
        chk($sformatf("vec%0d_rsp_data", i), 128'(bus.rsp_data), {4{v.exp_rsp}});
        chk($sformatf("vec%0d_rsp_rd", i), 128'(bus.rsp_rd), 128'(i + 1));
        chk($sformatf("vec%0d_rsp_wb", i), 128'(bus.rsp_wb), 128'(v.wb));
        chk($sformatf("vec%0d_rsp_uuid", i), 128'(bus.rsp_uuid), 128'(i + 100));
        chk($sformatf("vec%0d_store", i), 128'(store[v.wid][v.addr]), 128'(v.exp_fin));
        step;
        settle;
        chk($sformatf("vec%0d_idle", i), 128'(bus.busy), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        //          wid   op    addr     imm?  imm    rs1            wb    pre            we    wdata          rsp            final
        vecs[0] = '{2'd0, 2'd0, 12'h300, 1'b0, 5'd0,  32'h12345678, 1'b1, 32'hDEADBEEF, 1'b1, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        vecs[1] = '{2'd0, 2'd1, 12'h300, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 32'h00000055, 1'b0, 32'h00000000, 32'h00000055, 32'h00000055};
        vecs[2] = '{2'd0, 2'd2, 12'h300, 1'b0, 5'd0,  32'h000000F0, 1'b1, 32'h000000FF, 1'b1, 32'h0000000F, 32'h000000FF, 32'h0000000F};
        vecs[3] = '{2'd1, 2'd1, 12'h305, 1'b0, 5'd0,  32'h00000F00, 1'b0, 32'h000000F0, 1'b1, 32'h00000FF0, 32'h000000F0, 32'h00000FF0};
        vecs[4] = '{2'd3, 2'd0, 12'h340, 1'b1, 5'h1F, 32'hAAAAAAAA, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0000001F, 32'hFFFFFFFF, 32'h0000001F};
        vecs[5] = '{2'd0, 2'd3, 12'h300, 1'b0, 5'd0,  32'h00000005, 1'b1, 32'h00000077, 1'b0, 32'h00000000, 32'h00000077, 32'h00000077};
        vecs[6] = '{2'd2, 2'd2, 12'h300, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 32'h00001234, 1'b0, 32'h00000000, 32'h00001234, 32'h00001234};
        vecs[7] = '{2'd0, 2'd0, 12'h341, 1'b0, 5'd0,  32'h00000000, 1'b1, 32'h00000099, 1'b1, 32'h00000000, 32'h00000099, 32'h00000000};
        vecs[8] = '{2'd2, 2'd1, 12'h003, 1'b0, 5'd0,  32'h00000001, 1'b1, 32'h00000020, 1'b1, 32'h00000021, 32'h00000020, 32'h00000021};
        vecs[9] = '{2'd1, 2'd2, 12'h301, 1'b1, 5'd5,  32'h00000000, 1'b1, 32'h0000FFFF, 1'b1, 32'h0000FFFA, 32'h0000FFFF, 32'h0000FFFA};

        reset = 1'b0;
        pre_en = 1'b0; pre_wid = '0; pre_addr = '0; pre_data = '0;
        drive_req(2'd0, 2'd0, 12'h0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 44'd0);
        bus.req_valid = 1'b0;
        bus.fpu_pending = 4'b0;
        bus.rsp_ready = 1'b1;
        step; step;
        chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_req_ready", 128'(bus.req_ready), 128'(0));
        chk("rst_read_en", 128'(bus.read_enable), 128'(0));
        chk("rst_write_en", 128'(bus.write_enable), 128'(0));
        chk("rst_rsp_data", 128'(bus.rsp_data), 128'(0));
        reset = 1'b1;
        step;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Back-to-back: RW 5 then RS 2 on the same CSR.
        preload(2'd0, 12'h300, 32'd0);
        drive_req(2'd0, 2'd0, 12'h300, 1'b0, 5'd0, 32'd5, 5'd1, 1'b1, 44'd200);
        step;
        drive_req(2'd0, 2'd1, 12'h300, 1'b0, 5'd0, 32'd2, 5'd2, 1'b1, 44'd201);
        settle;
        chk("b2b_req_ready", 128'(bus.req_ready), 128'(1));
        chk("b2b_wd1", 128'(bus.write_data), 128'(5));
        step;
        bus.req_valid = 1'b0;
        settle;
        chk("b2b_read_en2", 128'(bus.read_enable), 128'(1));
        chk("b2b_wd2", 128'(bus.write_data), 128'(7));
        chk("b2b_rsp1_valid", 128'(bus.rsp_valid), 128'(1));
        chk("b2b_rsp1_data", 128'(bus.rsp_data), 128'(0));
        step;
        settle;
        chk("b2b_rsp2_valid", 128'(bus.rsp_valid), 128'(1));
        chk("b2b_rsp2_data", 128'(bus.rsp_data), {4{32'd5}});
        step;
        settle;
        chk("b2b_drained", 128'(bus.rsp_valid), 128'(0));
        chk("b2b_store", 128'(store[0][12'h300]), 128'(7));

        // FP hazard on FCSR for warp 1.
        preload(2'd1, 12'h003, 32'h5);
        bus.fpu_pending = 4'b0010;
        drive_req(2'd1, 2'd0, 12'h003, 1'b0, 5'd0, 32'hA, 5'd4, 1'b1, 44'd300);
        step;
        bus.req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle;
            chk($sformatf("haz%0d_read_en", c), 128'(bus.read_enable), 128'(0));
            chk($sformatf("haz%0d_write_en", c), 128'(bus.write_enable), 128'(0));
            chk($sformatf("haz%0d_req_ready", c), 128'(bus.req_ready), 128'(0));
            step;
        end
        bus.fpu_pending = 4'b0000;
        settle;
        chk("haz_clear_read_en", 128'(bus.read_enable), 128'(1));
        chk("haz_clear_wd", 128'(bus.write_data), 128'(32'hA));
        step;
        settle;
        chk("haz_rsp_data", 128'(bus.rsp_data), {4{32'h5}});
        step;

        // Pending FPU ops on warp 1 do not stall warp 0.
        preload(2'd0, 12'h003, 32'h3);
        bus.fpu_pending = 4'b0010;
        drive_req(2'd0, 2'd2, 12'h003, 1'b0, 5'd0, 32'h1, 5'd5, 1'b1, 44'd301);
        step;
        bus.req_valid = 1'b0;
        settle;
        chk("otherwarp_read_en", 128'(bus.read_enable), 128'(1));
        chk("otherwarp_wd", 128'(bus.write_data), 128'(2));
        step; step;
        bus.fpu_pending = 4'b0000;

        // Writeback backpressure with two requests queued.
        preload(2'd0, 12'h300, 32'h10);
        bus.rsp_ready = 1'b0;
        drive_req(2'd0, 2'd0, 12'h300, 1'b0, 5'd0, 32'h20, 5'd6, 1'b1, 44'd400);
        step;
        drive_req(2'd0, 2'd1, 12'h300, 1'b0, 5'd0, 32'h1, 5'd7, 1'b1, 44'd401);
        settle;
        chk("bp_first_wd", 128'(bus.write_data), 128'(32'h20));
        step;
        bus.req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle;
            chk($sformatf("bp%0d_rsp_valid", c), 128'(bus.rsp_valid), 128'(1));
            chk($sformatf("bp%0d_rsp_data", c), 128'(bus.rsp_data), {4{32'h10}});
            chk($sformatf("bp%0d_read_en", c), 128'(bus.read_enable), 128'(0));
            chk($sformatf("bp%0d_write_en", c), 128'(bus.write_enable), 128'(0));
            chk($sformatf("bp%0d_req_ready", c), 128'(bus.req_ready), 128'(0));
            step;
        end
        bus.rsp_ready = 1'b1;
        settle;
        chk("bp_rel_rsp_rd", 128'(bus.rsp_rd), 128'(6));
        chk("bp_rel_read_en", 128'(bus.read_enable), 128'(1));
        chk("bp_rel_wd", 128'(bus.write_data), 128'(32'h21));
        step;
        settle;
        chk("bp_rsp2_valid", 128'(bus.rsp_valid), 128'(1));
        chk("bp_rsp2_rd", 128'(bus.rsp_rd), 128'(7));
        chk("bp_rsp2_data", 128'(bus.rsp_data), {4{32'h20}});
        step;
        settle;
        chk("bp_store", 128'(store[0][12'h300]), 128'(32'h21));

        // Reset with both stages full.
        preload(2'd0, 12'h300, 32'h40);
        bus.rsp_ready = 1'b0;
        drive_req(2'd0, 2'd0, 12'h300, 1'b0, 5'd0, 32'h50, 5'd8, 1'b1, 44'd500);
        step;
        drive_req(2'd0, 2'd0, 12'h300, 1'b0, 5'd0, 32'h60, 5'd9, 1'b1, 44'd501);
        step;
        bus.req_valid = 1'b0;
        settle;
        chk("rst2_busy_before", 128'(bus.busy), 128'(1));
        reset = 1'b0;
        settle;
        chk("rst2_req_ready", 128'(bus.req_ready), 128'(0));
        chk("rst2_write_en", 128'(bus.write_enable), 128'(0));
        step;
        settle;
        chk("rst2_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("rst2_busy", 128'(bus.busy), 128'(0));
        chk("rst2_write_en_after", 128'(bus.write_enable), 128'(0));
        chk("rst2_rsp_data", 128'(bus.rsp_data), 128'(0));
        chk("rst2_store", 128'(store[0][12'h300]), 128'(32'h50));
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        step;
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
